// File: rtl/b10_field_extender_pkg.sv
// BCD constants and FSM encoding shared by the
// ten's-complement field extender.
package b10_field_extender_pkg;

  localparam logic [3:0] BCD_NINE = 4'b1001;
  localparam logic [3:0] BCD_ZERO = 4'b0000;
  localparam logic [3:0] BCD_HALF = 4'b0101;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/b10_field_extender_if.sv
// Parallel-in / serial-out handshake bundle
// of the BCD field extender.
interface b10_field_extender_if #(
  parameter int N_IN = 4
);

  logic [4*N_IN-1:0] in_digits;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        out_digit;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_neg;
  logic              err;

  modport master (
    output in_digits, in_valid, out_ready,
    input  in_ready, out_digit, out_valid,
    input  out_last, out_neg, err
  );

  modport slave (
    input  in_digits, in_valid, out_ready,
    output in_ready, out_digit, out_valid,
    output out_last, out_neg, err
  );

endinterface

// File: rtl/b10_digit_checker.sv
// Per-digit classifier: sign half and
// non-BCD detection.
module b10_digit_checker
  import b10_field_extender_pkg::*;
(
  input  logic [3:0] digit,
  output logic       ge5,
  output logic       bad
);

  assign ge5 = (digit >= BCD_HALF);
  assign bad = (digit > BCD_NINE);

endmodule

// File: rtl/b10_field_extender.sv
// Sign-extends an N_IN-digit ten's-complement
// BCD word to N_OUT digits, emitted LSD first.
module b10_field_extender
  import b10_field_extender_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8
) (
  input logic                 clock,
  input logic                 reset_,
  b10_field_extender_if.slave bus
);

  localparam int CW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_OUT - 1);

  logic [N_IN-1:0] ge5;
  logic [N_IN-1:0] bad;

  for (genvar k = 0; k < N_IN; k++) begin : g_chk
    b10_digit_checker u_chk (
      .digit (bus.in_digits[4*k +: 4]),
      .ge5   (ge5[k]),
      .bad   (bad[k])
    );
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*N_IN-1:0] word_q, word_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_digit_q, out_digit_d;
  logic              out_last_q, out_last_d;

  logic [3:0]         pad;
  logic [CW-1:0]      cnt_nxt;
  logic [4*N_OUT-1:0] ext;
  logic [4*N_OUT-1:0] ext_sh;

  // Full-width extended word, so the next digit is a plain shift.
  always_comb begin
    pad     = neg_q ? BCD_NINE : BCD_ZERO;
    ext     = {N_OUT{pad}};
    ext[4*N_IN-1:0] = word_q;
    cnt_nxt = cnt_q + CW'(1);
    ext_sh  = ext >> {cnt_nxt, 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    neg_d       = neg_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_digit_d = out_digit_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d     = SEND;
          cnt_d       = '0;
          word_d      = bus.in_digits;
          neg_d       = ge5[N_IN-1];
          err_d       = err_q | (|bad);
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_digit_d = bus.in_digits[3:0];
          out_last_d  = (N_OUT == 1);
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            cnt_d       = cnt_nxt;
            out_digit_d = ext_sh[3:0];
            out_last_d  = (cnt_nxt == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_digit_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      neg_q       <= neg_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_neg   = neg_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_b10_field_extender.sv
// Bench for b10_field_extender: vector table,
// corner sequences and random words vs a numeric model.
module tb_b10_field_extender;

  logic clk = 1'b0;
  logic reset_;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  b10_field_extender_if #(.N_IN(4)) ifc ();

  b10_field_extender #(
    .N_IN  (4),
    .N_OUT (8)
  ) dut (
    .clock  (clk),
    .reset_ (reset_),
    .bus    (ifc)
  );

  typedef struct {
    logic [15:0] w;
    logic [31:0] exp;
    logic        neg;
    logic        err;
    int          sat;
    int          sn;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Value-level model: decode ten's complement, re-encode on 8 digits.
  function automatic logic [31:0] model(input logic [15:0] w);
    longint v = 0;
    bit nb = 0;
    logic [31:0] r = '0;
    for (int k = 3; k >= 0; k--) begin
      if (w[4*k +: 4] > 4'd9) nb = 1;
      v = v * 10 + longint'(w[4*k +: 4]);
    end
    if (nb) begin
      r[15:0] = w;
      r[31:16] = (w[15:12] >= 4'd5) ? 16'h9999 : 16'h0000;
    end else begin
      if (w[15:12] >= 4'd5) v = v - 10000;
      v = (v + 100000000) % 100000000;
      for (int k = 0; k < 8; k++) begin
        r[4*k +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  task automatic send_word(input logic [15:0] w, input int stall_at,
                           input int stall_n, input int pct,
                           output logic [31:0] got, output int last_idx,
                           output logic neg_seen);
    int n;
    int waits;
    int stalls;
    logic held;
    logic [3:0] hd;
    got = '0;
    last_idx = -1;
    neg_seen = 1'b0;
    n = 0;
    stalls = 0;
    held = 1'b0;
    hd = '0;
    @(negedge clk);
    ifc.in_digits = w;
    ifc.in_valid = 1'b1;
    ifc.out_ready = 1'b0;
    waits = 0;
    while (!ifc.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ifc.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check("first_valid", 32'(ifc.out_valid), 32'd1);
    waits = 0;
    while (n < 8 && waits < 400) begin
      if (!ifc.out_valid) begin
        check("valid_in_send", 32'd0, 32'd1);
        break;
      end
      if (held) check("hold_digit", 32'(ifc.out_digit), 32'(hd));
      if (n == stall_at && stalls < stall_n) begin
        ifc.out_ready = 1'b0;
        stalls++;
      end else begin
        ifc.out_ready = ($urandom_range(99) >= pct);
      end
      if (ifc.out_ready) begin
        got[4*n +: 4] = ifc.out_digit;
        if (ifc.out_last && last_idx < 0) last_idx = n;
        neg_seen = ifc.out_neg;
        n++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd = ifc.out_digit;
      end
      @(negedge clk);
      waits++;
    end
    ifc.out_ready = 1'b0;
    if (n < 8) check("stream_len", 32'(n), 32'd8);
    check("in_ready_after", 32'(ifc.in_ready), 32'd1);
    check("valid_after", 32'(ifc.out_valid), 32'd0);
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] got;
    int li;
    logic ng;
    logic [15:0] w;

    tbl[0] = '{16'h0123, 32'h00000123, 1'b0, 1'b0, -1, 0};
    tbl[1] = '{16'h9876, 32'h99999876, 1'b1, 1'b0, -1, 0};
    tbl[2] = '{16'h4999, 32'h00004999, 1'b0, 1'b0, -1, 0};
    tbl[3] = '{16'h5000, 32'h99995000, 1'b1, 1'b0, -1, 0};
    tbl[4] = '{16'h0123, 32'h00000123, 1'b0, 1'b0, 2, 3};
    tbl[5] = '{16'h00A1, 32'h000000A1, 1'b0, 1'b1, -1, 0};

    reset_ = 1'b0;
    ifc.in_digits = '0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_last", 32'(ifc.out_last), 32'd0);
    check("rst_out_neg", 32'(ifc.out_neg), 32'd0);
    check("rst_err", 32'(ifc.err), 32'd0);
    check("rst_out_digit", 32'(ifc.out_digit), 32'd0);
    reset_ = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].w, tbl[i].sat, tbl[i].sn, 0, got, li, ng);
      check($sformatf("tbl%0d_digits", i), got, tbl[i].exp);
      check($sformatf("tbl%0d_last", i), 32'(li), 32'd7);
      check($sformatf("tbl%0d_neg", i), 32'(ng), 32'(tbl[i].neg));
      check($sformatf("tbl%0d_err", i), 32'(ifc.err), 32'(tbl[i].err));
    end

    send_word(16'h0042, -1, 0, 0, got, li, ng);
    check("sticky_digits", got, 32'h00000042);
    check("sticky_err", 32'(ifc.err), 32'd1);

    // Abort a word with reset while its 4th digit is on the output.
    @(negedge clk);
    check("abort_in_ready", 32'(ifc.in_ready), 32'd1);
    ifc.in_digits = 16'h4123;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_digit3", 32'(ifc.out_digit), 32'h4);
    reset_ = 1'b0;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
    check("abort_in_ready2", 32'(ifc.in_ready), 32'd1);
    check("abort_err", 32'(ifc.err), 32'd0);
    check("abort_out_last", 32'(ifc.out_last), 32'd0);
    reset_ = 1'b1;
    send_word(16'h0001, -1, 0, 0, got, li, ng);
    check("after_abort_digits", got, 32'h00000001);
    check("after_abort_last", 32'(li), 32'd7);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) w[4*k +: 4] = 4'($urandom_range(9));
      send_word(w, -1, 0, 30, got, li, ng);
      check($sformatf("rnd%0d_digits", i), got, model(w));
      check($sformatf("rnd%0d_neg", i), 32'(ng), 32'(w[15:12] >= 4'd5));
      check($sformatf("rnd%0d_last", i), 32'(li), 32'd7);
      check($sformatf("rnd%0d_err", i), 32'(ifc.err), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b10_field_extender.md
Name: b10_field_extender

Overview:
Sign-extends an N_IN-digit BCD integer in ten's-complement code to N_OUT digits. It is the widening counterpart of the BCD field reducer in the datapath. A parallel word is accepted via valid/ready and emitted serially, LSD first, one digit per accepted beat on a valid/ready output stream. The output feeds the serial BCD adders and the display drivers.

Parameters:
N_IN, 4, number of input digits (>= 1)
N_OUT, 8, number of output digits (>= N_IN; N_OUT == N_IN is a pass-through serializer)

Ports:
clock  in  1  system clock, rising edge
reset_  in  1  synchronous, active-low reset
in_digits  in  4*N_IN  input number; digit k at bits [4k+3:4k], digit 0 = LSD
in_valid  in  1  in_digits is valid
in_ready  out  1  block can accept a word
out_digit  out  4  current output digit
out_valid  out  1  out_digit is valid
out_ready  in  1  consumer takes out_digit
out_last  out  1  current digit is digit N_OUT-1
out_neg  out  1  sign of the word in flight (1 = negative)
err  out  1  sticky: a non-BCD digit (> 4'B1001) was accepted

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-low on reset_.
- Reset values:
  - in_ready=1, out_valid=0, out_last=0, out_neg=0, err=0, out_digit=0.
  - Digit counter = 0; FSM = IDLE.
- Sign rule: negative iff the input MSD (digit N_IN-1) >= 4'B0101.
  - Pad digit = 4'B1001 if negative, else 4'B0000.
- FSM IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register the word and out_neg, clear the counter, go to SEND.
  - Latency: first digit valid the cycle after acceptance.
- FSM SEND:
  - in_ready=0, out_valid=1.
  - out_digit = registered digit[cnt] for cnt < N_IN, else the pad digit.
  - out_last = (cnt == N_OUT-1).
  - On out_ready:
    - If out_last, go to IDLE (in_ready=1 the following cycle).
    - Otherwise cnt increments.
  - Without out_ready: out_digit, out_last and out_neg are held stable; the counter does not wrap.
- Throughput: one word per N_OUT+1 cycles; no back-to-back overlap is required.
- in_valid while in SEND is ignored; the producer holds the word until in_ready.
- err:
  - Set at acceptance if any input digit > 9. The word is still emitted unchanged, with digits passed raw.
  - Cleared only by reset.
- out_neg stays valid through SEND and holds its last value in IDLE.
- Reset asserted mid-SEND: the word is aborted, the next cycle shows reset values, and no further digits are emitted.
- Counter width: clog2(N_OUT), minimum 1.

Decomposition:
- Shared header (`include`): BCD constants BCD_NINE=4'B1001, BCD_ZERO=4'B0000, BCD_HALF=4'B0101, and the FSM state encodings IDLE/SEND.
- Sub-module b10_digit_checker, combinational, one instance per input digit. Outputs:
  - ge5: digit >= 5 (sign detect on the MSD);
  - bad: digit > 9.
- The top level ORs the bad outputs into err and uses ge5 of the MSD as the sign.

Test Plan:
1. Reset, N_IN=4, N_OUT=8, accept 0x0123, out_ready=1 -> digits 3,2,1,0,0,0,0,0; out_last on the 8th; out_neg=0; in_ready=1 one cycle later.
2. Accept 0x9876 (negative) -> digits 6,7,8,9,9,9,9,9; out_neg=1; err=0.
3. Boundary MSD 0x4999 -> pad 0; 0x5000 -> pad 9 and out_neg=1.
4. Backpressure: for 0x0123, drop out_ready for 3 cycles on digit 2 -> out_digit held at 1, counter held; the stream resumes with no digit lost or duplicated.
5. Accept 0x00A1 -> err=1 and stays 1; digits 1,A,0,0,0,0,0,0 emitted; err clears only on reset_=0.
6. reset_=0 at the 4th digit -> next cycle out_valid=0, in_ready=1, err=0; a new word 0x0001 emits from digit 0.
